// File: rtl/reservation_station.sv
// Unified reservation station: captures dispatched instructions with their
// source tags/values, wakes pending operands from the CDB, and issues the
// oldest fully-ready entry to the functional units.
//
// Issue handshake: issue_valid is asserted while at least one entry has both
// operands ready, with issue_* carrying the oldest such entry. A transfer
// happens on a rising edge where issue_valid && issue_ready; that entry is
// freed at the same edge. While issue_ready is low the outputs stay on the
// same entry unless an older entry becomes ready, which then takes over.
module reservation_station #(
    parameter int RS_SIZE = 4,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32,
    parameter int PAY_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         disp_valid,
    input  logic [TAG_W-1:0]             disp_rob_tag,
    input  logic [PAY_W-1:0]             disp_payload,
    input  logic [TAG_W-1:0]             src1_tag,
    input  logic                         src1_tplus,
    input  logic [XLEN-1:0]              src1_value,
    input  logic [TAG_W-1:0]             src2_tag,
    input  logic                         src2_tplus,
    input  logic [XLEN-1:0]              src2_value,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [XLEN-1:0]              cdb_value,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [TAG_W-1:0]             issue_rob_tag,
    output logic [PAY_W-1:0]             issue_payload,
    output logic [XLEN-1:0]              issue_op1,
    output logic [XLEN-1:0]              issue_op2,
    output logic                         full,
    output logic [$clog2(RS_SIZE):0]     free_count
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    // Entry state
    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   rob_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   rob_tag_d [RS_SIZE];
    logic [PAY_W-1:0]   payload_q [RS_SIZE];
    logic [PAY_W-1:0]   payload_d [RS_SIZE];
    logic [RS_SIZE-1:0] s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [TAG_W-1:0]   s1_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   s1_tag_d [RS_SIZE];
    logic [TAG_W-1:0]   s2_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   s2_tag_d [RS_SIZE];
    logic [XLEN-1:0]    s1_val_q [RS_SIZE];
    logic [XLEN-1:0]    s1_val_d [RS_SIZE];
    logic [XLEN-1:0]    s2_val_q [RS_SIZE];
    logic [XLEN-1:0]    s2_val_d [RS_SIZE];
    // age_q[i][j] = 1 means entry i is older than entry j
    logic [RS_SIZE-1:0] age_q [RS_SIZE];
    logic [RS_SIZE-1:0] age_d [RS_SIZE];

    // Select / allocate helpers
    logic [RS_SIZE-1:0] cand;
    logic [RS_SIZE-1:0] has_older;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic               alloc_found;
    logic [CNT_W-1:0]   free_cnt;
    logic               disp_fire;
    logic               issue_fire;
    logic               cdb_hit;

    // Oldest-ready select, lowest-free allocation and occupancy, all from registered state
    always_comb begin
        cand        = valid_q & s1_rdy_q & s2_rdy_q;
        has_older   = '0;
        sel_idx     = '0;
        alloc_idx   = '0;
        alloc_found = 1'b0;
        free_cnt    = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && age_q[j][i]) begin
                    has_older[i] = 1'b1;
                end
            end
            if (cand[i] && !has_older[i]) begin
                sel_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!alloc_found) begin
                    alloc_idx   = IDX_W'(i);
                    alloc_found = 1'b1;
                end
            end
        end
    end

    assign issue_valid   = |cand;
    assign issue_rob_tag = issue_valid ? rob_tag_q[sel_idx] : '0;
    assign issue_payload = issue_valid ? payload_q[sel_idx] : '0;
    assign issue_op1     = issue_valid ? s1_val_q[sel_idx]  : '0;
    assign issue_op2     = issue_valid ? s2_val_q[sel_idx]  : '0;
    assign full          = &valid_q;
    assign free_count    = free_cnt;

    assign disp_fire  = disp_valid && !full;
    assign issue_fire = issue_valid && issue_ready;
    assign cdb_hit    = cdb_valid && (cdb_tag != '0);

    // Next-state: squash flush, issue free, CDB wakeup, dispatch write and age update
    always_comb begin
        valid_d   = valid_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        rob_tag_d = rob_tag_q;
        payload_d = payload_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        s1_val_d  = s1_val_q;
        s2_val_d  = s2_val_q;
        age_d     = age_q;
        if (squash) begin
            valid_d = '0;
        end else begin
            if (issue_fire) begin
                valid_d[sel_idx] = 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && cdb_hit) begin
                    if (!s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
                        s1_rdy_d[i] = 1'b1;
                        s1_val_d[i] = cdb_value;
                    end
                    if (!s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
                        s2_rdy_d[i] = 1'b1;
                        s2_val_d[i] = cdb_value;
                    end
                end
            end
            // The allocated slot is free in registered state, so it never
            // collides with the slot being issued or woken this cycle.
            if (disp_fire) begin
                valid_d[alloc_idx]   = 1'b1;
                rob_tag_d[alloc_idx] = disp_rob_tag;
                payload_d[alloc_idx] = disp_payload;
                s1_tag_d[alloc_idx]  = src1_tag;
                s2_tag_d[alloc_idx]  = src2_tag;
                if (src1_tag == '0 || src1_tplus) begin
                    s1_rdy_d[alloc_idx] = 1'b1;
                    s1_val_d[alloc_idx] = src1_value;
                end else if (cdb_valid && cdb_tag == src1_tag) begin
                    s1_rdy_d[alloc_idx] = 1'b1;
                    s1_val_d[alloc_idx] = cdb_value;
                end else begin
                    s1_rdy_d[alloc_idx] = 1'b0;
                    s1_val_d[alloc_idx] = '0;
                end
                if (src2_tag == '0 || src2_tplus) begin
                    s2_rdy_d[alloc_idx] = 1'b1;
                    s2_val_d[alloc_idx] = src2_value;
                end else if (cdb_valid && cdb_tag == src2_tag) begin
                    s2_rdy_d[alloc_idx] = 1'b1;
                    s2_val_d[alloc_idx] = cdb_value;
                end else begin
                    s2_rdy_d[alloc_idx] = 1'b0;
                    s2_val_d[alloc_idx] = '0;
                end
                // New entry is youngest: nothing is younger than it, every
                // currently valid entry is older than it.
                age_d[alloc_idx] = '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (valid_q[j]) begin
                        age_d[j][alloc_idx] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                rob_tag_q[i] <= '0;
                payload_q[i] <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
                s1_val_q[i]  <= '0;
                s2_val_q[i]  <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            s1_rdy_q  <= s1_rdy_d;
            s2_rdy_q  <= s2_rdy_d;
            rob_tag_q <= rob_tag_d;
            payload_q <= payload_d;
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
            s1_val_q  <= s1_val_d;
            s2_val_q  <= s2_val_d;
            age_q     <= age_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues are queued when
// stimulus is applied and popped by a monitor on every accepted issue.
module tb_reservation_station;

    localparam int RS_SIZE = 4;
    localparam int TAG_W   = 5;
    localparam int XLEN    = 32;
    localparam int PAY_W   = 32;
    localparam int EW      = TAG_W + PAY_W + 2 * XLEN;

    logic                     clock;
    logic                     reset;
    logic                     squash;
    logic                     disp_valid;
    logic [TAG_W-1:0]         disp_rob_tag;
    logic [PAY_W-1:0]         disp_payload;
    logic [TAG_W-1:0]         src1_tag;
    logic                     src1_tplus;
    logic [XLEN-1:0]          src1_value;
    logic [TAG_W-1:0]         src2_tag;
    logic                     src2_tplus;
    logic [XLEN-1:0]          src2_value;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]          cdb_value;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [TAG_W-1:0]         issue_rob_tag;
    logic [PAY_W-1:0]         issue_payload;
    logic [XLEN-1:0]          issue_op1;
    logic [XLEN-1:0]          issue_op2;
    logic                     full;
    logic [$clog2(RS_SIZE):0] free_count;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    reservation_station #(
        .RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .XLEN(XLEN), .PAY_W(PAY_W)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .disp_valid(disp_valid), .disp_rob_tag(disp_rob_tag), .disp_payload(disp_payload),
        .src1_tag(src1_tag), .src1_tplus(src1_tplus), .src1_value(src1_value),
        .src2_tag(src2_tag), .src2_tplus(src2_tplus), .src2_value(src2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rob_tag(issue_rob_tag), .issue_payload(issue_payload),
        .issue_op1(issue_op1), .issue_op2(issue_op2),
        .full(full), .free_count(free_count)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [EW-1:0] pack(input logic [TAG_W-1:0] t, input logic [PAY_W-1:0] p,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return {t, p, a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change and checks sample 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        squash     = 1'b0;
    endtask

    task automatic dispatch(input logic [TAG_W-1:0] t, input logic [PAY_W-1:0] p,
                            input logic [TAG_W-1:0] t1, input logic tp1, input logic [XLEN-1:0] v1,
                            input logic [TAG_W-1:0] t2, input logic tp2, input logic [XLEN-1:0] v2);
        disp_valid   = 1'b1;
        disp_rob_tag = t;
        disp_payload = p;
        src1_tag     = t1;
        src1_tplus   = tp1;
        src1_value   = v1;
        src2_tag     = t2;
        src2_tplus   = tp2;
        src2_value   = v2;
    endtask

    task automatic broadcast(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
    endtask

    // Monitor: every accepted issue must match the head of the expected queue
    always @(negedge clock) begin
        logic [EW-1:0] exp_w;
        logic [EW-1:0] got_w;
        if (!reset && issue_valid && issue_ready) begin
            n_checks++;
            got_w = {issue_rob_tag, issue_payload, issue_op1, issue_op2};
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL issue_unexpected: got tag %0d payload 0x%0h, expected no issue",
                         issue_rob_tag, issue_payload);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL issue_data: got {tag,pay,op1,op2}=0x%0h, expected 0x%0h",
                             got_w, exp_w);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        issue_ready  = 1'b0;
        disp_rob_tag = '0;
        disp_payload = '0;
        src1_tag     = '0;
        src1_tplus   = 1'b0;
        src1_value   = '0;
        src2_tag     = '0;
        src2_tplus   = 1'b0;
        src2_value   = '0;
        cdb_tag      = '0;
        cdb_value    = '0;
        idle();
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_free_count", 64'(free_count), 64'd4);
        chk("rst_issue_tag", 64'(issue_rob_tag), 64'd0);
        chk("rst_issue_op1", 64'(issue_op1), 64'd0);
        chk("rst_issue_payload", 64'(issue_payload), 64'd0);

        // Ready operands at dispatch: src1 architectural, src2 via t_plus
        issue_ready = 1'b1;
        dispatch(5'd3, 32'h1003, 5'd0, 1'b0, 32'h10, 5'd4, 1'b1, 32'h20);
        exp_q.push_back(pack(5'd3, 32'h1003, 32'h10, 32'h20));
        step();
        idle();
        chk("t1_issue_valid", 64'(issue_valid), 64'd1);
        chk("t1_issue_tag", 64'(issue_rob_tag), 64'd3);
        chk("t1_free_count", 64'(free_count), 64'd3);
        step();
        chk("t1_free_after_issue", 64'(free_count), 64'd4);

        // Pending src1 woken by a later CDB broadcast
        dispatch(5'd5, 32'h1005, 5'd2, 1'b0, 32'hDEAD, 5'd0, 1'b0, 32'h7);
        step();
        idle();
        chk("t2_waiting", 64'(issue_valid), 64'd0);
        broadcast(5'd2, 32'hABCD);
        exp_q.push_back(pack(5'd5, 32'h1005, 32'hABCD, 32'h7));
        chk("t2_no_cdb_comb_path", 64'(issue_valid), 64'd0);
        step();
        idle();
        chk("t2_woken", 64'(issue_valid), 64'd1);
        chk("t2_op1", 64'(issue_op1), 64'hABCD);
        step();
        chk("t2_free_count", 64'(free_count), 64'd4);

        // Same-cycle CDB bypass into dispatch
        dispatch(5'd8, 32'h1008, 5'd0, 1'b0, 32'h1, 5'd7, 1'b0, 32'h999);
        broadcast(5'd7, 32'h55);
        exp_q.push_back(pack(5'd8, 32'h1008, 32'h1, 32'h55));
        step();
        idle();
        chk("t3_bypass_valid", 64'(issue_valid), 64'd1);
        chk("t3_bypass_op2", 64'(issue_op2), 64'h55);
        step();

        // Fill all entries on tag 9, drop extra dispatches, issue in age order
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            dispatch(TAG_W'(i), 32'h2000 + 32'(i), 5'd9, 1'b0, 32'h0, 5'd0, 1'b0, 32'h200 + 32'(i));
            step();
        end
        idle();
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_free_zero", 64'(free_count), 64'd0);
        dispatch(5'd6, 32'h2006, 5'd0, 1'b0, 32'h6, 5'd0, 1'b0, 32'h6);
        step();
        idle();
        chk("t4_still_full", 64'(full), 64'd1);
        chk("t4_none_ready", 64'(issue_valid), 64'd0);
        broadcast(5'd9, 32'h99);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(pack(TAG_W'(i), 32'h2000 + 32'(i), 32'h99, 32'h200 + 32'(i)));
        end
        step();
        idle();
        issue_ready = 1'b1;
        // Dispatch while full and issuing: must be dropped
        dispatch(5'd6, 32'h2006, 5'd0, 1'b0, 32'h6, 5'd0, 1'b0, 32'h6);
        step();
        idle();
        chk("t4_free_after_first", 64'(free_count), 64'd1);
        chk("t4_not_full", 64'(full), 64'd0);
        step();
        step();
        step();
        chk("t4_drained_free", 64'(free_count), 64'd4);
        chk("t4_drained_valid", 64'(issue_valid), 64'd0);

        // Older entry waking preempts a stalled younger one
        issue_ready = 1'b0;
        dispatch(5'd2, 32'h3002, 5'd10, 1'b0, 32'h0, 5'd0, 1'b0, 32'h2);
        step();
        dispatch(5'd4, 32'h3004, 5'd11, 1'b0, 32'h0, 5'd0, 1'b0, 32'h4);
        step();
        idle();
        broadcast(5'd11, 32'h44);
        step();
        idle();
        chk("t5_young_valid", 64'(issue_valid), 64'd1);
        chk("t5_young_tag", 64'(issue_rob_tag), 64'd4);
        step();
        chk("t5_young_stable", 64'(issue_rob_tag), 64'd4);
        broadcast(5'd10, 32'h22);
        step();
        idle();
        chk("t5_preempt_tag", 64'(issue_rob_tag), 64'd2);
        chk("t5_preempt_op1", 64'(issue_op1), 64'h22);
        exp_q.push_back(pack(5'd2, 32'h3002, 32'h22, 32'h2));
        exp_q.push_back(pack(5'd4, 32'h3004, 32'h44, 32'h4));
        issue_ready = 1'b1;
        step();
        step();
        chk("t5_free_count", 64'(free_count), 64'd4);

        // Squash with a simultaneous dispatch clears everything
        issue_ready = 1'b0;
        for (int i = 13; i <= 15; i++) begin
            dispatch(TAG_W'(i), 32'h4000 + 32'(i), 5'd12, 1'b0, 32'h0, 5'd0, 1'b0, 32'h1);
            step();
        end
        idle();
        chk("t6_three_valid", 64'(free_count), 64'd1);
        dispatch(5'd16, 32'h4016, 5'd0, 1'b0, 32'h1, 5'd0, 1'b0, 32'h2);
        squash = 1'b1;
        step();
        idle();
        chk("t6_free_count", 64'(free_count), 64'd4);
        chk("t6_issue_valid", 64'(issue_valid), 64'd0);
        chk("t6_full", 64'(full), 64'd0);
        issue_ready = 1'b1;
        broadcast(5'd12, 32'h12);
        step();
        idle();
        step();
        chk("t6_nothing_issues", 64'(issue_valid), 64'd0);
        chk("t6_still_empty", 64'(free_count), 64'd4);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
